// File: rtl/nn_load_sched.sv
// Streams a 3-layer network's weights and biases from a config port into addressed strobes.
// Optional end-of-load checksum word: define NN_LOAD_CHECKSUM_EN.
module nn_load_sched #(
    parameter int data_width = 16,
    parameter int L1_NEURONS = 30,
    parameter int L2_NEURONS = 30,
    parameter int L3_NEURONS = 10,
    parameter int L1_WEIGHTS = 784,
    parameter int L2_WEIGHTS = 30,
    parameter int L3_WEIGHTS = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [data_width-1:0]   cfg_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [data_width-1:0]   weight_out,
    output logic                    weight_valid,
    output logic [2*data_width-1:0] bias_out,
    output logic                    bias_valid,
    output logic [1:0]              layer_sel,
    output logic [7:0]              neuron_sel,
    output logic [9:0]              weight_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    start_err,
`ifdef NN_LOAD_CHECKSUM_EN
    output logic                    chk_err,
`endif
    output logic [2:0]              state_dbg
);

    // Handshake: a cfg word transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready depends only on state, and the source must hold cfg_data until it transfers.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WEIGHT  = 3'd1,
        S_BIAS_LO = 3'd2,
        S_BIAS_HI = 3'd3,
        S_FINISH  = 3'd4
`ifdef NN_LOAD_CHECKSUM_EN
        , S_CHECK = 3'd5
`endif
    } state_t;

    localparam logic [9:0] L1_LAST_W = 10'(L1_WEIGHTS - 1);
    localparam logic [9:0] L2_LAST_W = 10'(L2_WEIGHTS - 1);
    localparam logic [9:0] L3_LAST_W = 10'(L3_WEIGHTS - 1);
    localparam logic [7:0] L1_LAST_N = 8'(L1_NEURONS - 1);
    localparam logic [7:0] L2_LAST_N = 8'(L2_NEURONS - 1);
    localparam logic [7:0] L3_LAST_N = 8'(L3_NEURONS - 1);

    state_t                state, state_nxt;
    logic [1:0]            layer;
    logic [7:0]            neuron;
    logic [9:0]            idx;
    logic [data_width-1:0] bias_lo;
    logic [9:0]            last_w;
    logic [7:0]            last_n;
    logic                  accept;
    logic                  last_neuron_of_net;
`ifdef NN_LOAD_CHECKSUM_EN
    logic [data_width-1:0] sum;
`endif

    always_comb begin
        last_w = L3_LAST_W;
        last_n = L3_LAST_N;
        case (layer)
            2'd0: begin
                last_w = L1_LAST_W;
                last_n = L1_LAST_N;
            end
            2'd1: begin
                last_w = L2_LAST_W;
                last_n = L2_LAST_N;
            end
            default: ;
        endcase
    end

    assign accept             = cfg_valid && cfg_ready;
    assign last_neuron_of_net = (neuron == last_n) && (layer == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_WEIGHT;
            S_WEIGHT:  if (accept && idx == last_w) state_nxt = S_BIAS_LO;
            S_BIAS_LO: if (accept) state_nxt = S_BIAS_HI;
            S_BIAS_HI: begin
                if (accept) begin
`ifdef NN_LOAD_CHECKSUM_EN
                    state_nxt = last_neuron_of_net ? S_CHECK : S_WEIGHT;
`else
                    state_nxt = last_neuron_of_net ? S_FINISH : S_WEIGHT;
`endif
                end
            end
`ifdef NN_LOAD_CHECKSUM_EN
            S_CHECK:   if (accept) state_nxt = (cfg_data == sum) ? S_FINISH : S_IDLE;
`endif
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = (state != S_IDLE);
        done      = (state == S_FINISH);
        state_dbg = state;
        case (state)
            S_WEIGHT, S_BIAS_LO, S_BIAS_HI: cfg_ready = 1'b1;
`ifdef NN_LOAD_CHECKSUM_EN
            S_CHECK:                        cfg_ready = 1'b1;
`endif
            default: ;
        endcase
    end

    // Counters, strobes and the registered address outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer        <= '0;
            neuron       <= '0;
            idx          <= '0;
            bias_lo      <= '0;
            weight_out   <= '0;
            weight_valid <= 1'b0;
            bias_out     <= '0;
            bias_valid   <= 1'b0;
            layer_sel    <= '0;
            neuron_sel   <= '0;
            weight_idx   <= '0;
            start_err    <= 1'b0;
`ifdef NN_LOAD_CHECKSUM_EN
            sum          <= '0;
            chk_err      <= 1'b0;
`endif
        end else begin
            weight_valid <= 1'b0;
            bias_valid   <= 1'b0;
            start_err    <= start && (state != S_IDLE);
`ifdef NN_LOAD_CHECKSUM_EN
            chk_err      <= 1'b0;
`endif
            if (state == S_IDLE && start) begin
                layer  <= '0;
                neuron <= '0;
                idx    <= '0;
`ifdef NN_LOAD_CHECKSUM_EN
                sum    <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_WEIGHT: begin
                        weight_out   <= cfg_data;
                        weight_valid <= 1'b1;
                        layer_sel    <= layer;
                        neuron_sel   <= neuron;
                        weight_idx   <= idx;
                        idx          <= (idx == last_w) ? 10'd0 : idx + 10'd1;
`ifdef NN_LOAD_CHECKSUM_EN
                        sum          <= sum + cfg_data;
`endif
                    end
                    S_BIAS_LO: begin
                        bias_lo <= cfg_data;
`ifdef NN_LOAD_CHECKSUM_EN
                        sum     <= sum + cfg_data;
`endif
                    end
                    S_BIAS_HI: begin
                        bias_out   <= {cfg_data, bias_lo};
                        bias_valid <= 1'b1;
                        layer_sel  <= layer;
                        neuron_sel <= neuron;
`ifdef NN_LOAD_CHECKSUM_EN
                        sum        <= sum + cfg_data;
`endif
                        if (neuron != last_n) begin
                            neuron <= neuron + 8'd1;
                        end else if (layer != 2'd2) begin
                            layer  <= layer + 2'd1;
                            neuron <= '0;
                        end
                    end
`ifdef NN_LOAD_CHECKSUM_EN
                    S_CHECK: chk_err <= (cfg_data != sum);
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
